// File: rtl/sdram_pattern_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ===========================================================================
// Module : sdram_pattern_checker
// SDRAM fill / read-back / compare tester on the controller command port.
// Rev    : 1.0
// ===========================================================================

module sdram_pattern_checker #(
  parameter int                    ADDR_WIDTH    = 22,
  parameter int                    DATA_WIDTH    = 16,
  parameter int                    BURST_LENGTH  = 1,
  parameter int                    NUM_PASSES    = 1,
  parameter bit                    STOP_ON_ERROR = 1'b1,
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS     = 16'hB400,
  parameter logic [DATA_WIDTH-1:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  output logic [1:0]            command,
  output logic [ADDR_WIDTH-1:0] data_address,
  output logic [DATA_WIDTH-1:0] data_write,
  input  logic                  data_write_done,
  input  logic [DATA_WIDTH-1:0] data_read,
  input  logic                  data_read_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           error_count,
  output logic [7:0]            pass_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [DATA_WIDTH-1:0] first_err_expected,
  output logic [DATA_WIDTH-1:0] first_err_actual
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_WGAP  = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_RGAP  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int                BEAT_W      = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LENGTH - 1);
  // pass_count is 8 bits wide, so a finite pass target is taken modulo 256
  localparam logic [7:0]        PASS_TARGET = 8'(NUM_PASSES);

  logic [2:0]            state;
  logic [1:0]            test_mode;
  logic [BEAT_W-1:0]     beat;
  logic [DATA_WIDTH-1:0] lfsr;
  logic                  stop_req;

  logic [DATA_WIDTH-1:0] addr_lo;
  logic [DATA_WIDTH-1:0] addr_hi;
  logic [DATA_WIDTH-1:0] base_word;
  logic [DATA_WIDTH-1:0] exp_word;
  logic [DATA_WIDTH-1:0] lfsr_next;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [7:0]            pass_next;
  logic                  start_ok;
  logic                  write_beat;
  logic                  read_beat;
  logic                  mismatch;
  logic                  last_beat;

  assign addr_lo   = DATA_WIDTH'(data_address);
  assign addr_hi   = DATA_WIDTH'(data_address >> DATA_WIDTH);
  assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
  assign addr_next = data_address + ADDR_WIDTH'(1);
  assign pass_next = pass_count + 8'd1;

  always_comb begin
    case (test_mode)
      2'd0:    base_word = addr_lo;
      2'd1:    base_word = addr_lo ^ addr_hi;
      2'd2:    base_word = lfsr;
      default: base_word = ~addr_lo;
    endcase
  end

  // Odd passes store the complement so every cell sees both polarities
  assign exp_word   = base_word ^ {DATA_WIDTH{pass_count[0]}};
  assign start_ok   = start && ((state == S_IDLE) || (state == S_DONE));
  assign write_beat = (state == S_WRITE) && data_write_done;
  assign read_beat  = (state == S_READ) && data_read_valid;
  assign mismatch   = read_beat && (data_read != exp_word);
  assign last_beat  = (beat == LAST_BEAT);

  always_comb begin
    case (state)
      S_WRITE: command = 2'd1;
      S_READ:  command = 2'd2;
      default: command = 2'd0;
    endcase
  end

  assign data_write = (state == S_WRITE) ? exp_word : '0;
  assign busy       = (state == S_WRITE) || (state == S_WGAP) ||
                      (state == S_READ)  || (state == S_RGAP);
  assign done       = (state == S_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= S_IDLE;
      test_mode          <= 2'd0;
      beat               <= '0;
      lfsr               <= LFSR_SEED;
      stop_req           <= 1'b0;
      data_address       <= '0;
      error              <= 1'b0;
      error_count        <= 16'd0;
      pass_count         <= 8'd0;
      first_err_addr     <= '0;
      first_err_expected <= '0;
      first_err_actual   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            state              <= S_WRITE;
            test_mode          <= mode;
            beat               <= '0;
            lfsr               <= LFSR_SEED;
            stop_req           <= 1'b0;
            data_address       <= '0;
            error              <= 1'b0;
            error_count        <= 16'd0;
            pass_count         <= 8'd0;
            first_err_addr     <= '0;
            first_err_expected <= '0;
            first_err_actual   <= '0;
          end
        end
        S_WRITE: begin
          if (write_beat) begin
            data_address <= addr_next;
            lfsr         <= lfsr_next;
            if (last_beat) begin
              beat  <= '0;
              state <= S_WGAP;
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end
        end
        S_WGAP: begin
          if (data_address == '0) begin
            state <= S_READ;
            lfsr  <= LFSR_SEED;
          end else begin
            state <= S_WRITE;
          end
        end
        S_READ: begin
          if (read_beat) begin
            data_address <= addr_next;
            lfsr         <= lfsr_next;
            if (last_beat) begin
              beat  <= '0;
              state <= S_RGAP;
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end
          if (mismatch) begin
            error <= 1'b1;
            if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
            if (!error) begin
              first_err_addr     <= data_address;
              first_err_expected <= exp_word;
              first_err_actual   <= data_read;
            end
            if (STOP_ON_ERROR) stop_req <= 1'b1;
          end
        end
        S_RGAP: begin
          if (stop_req) begin
            state <= S_DONE;
          end else if (data_address == '0) begin
            pass_count <= pass_next;
            lfsr       <= LFSR_SEED;
            if ((NUM_PASSES != 0) && (pass_next == PASS_TARGET)) state <= S_DONE;
            else                                                  state <= S_WRITE;
          end else begin
            state <= S_READ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sdram_pattern_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ===========================================================================
// Module : tb_sdram_pattern_checker
// Self-checking bench with behavioural SDRAM models for sdram_pattern_checker.
// ===========================================================================

module tb_sdram_pattern_checker;

  typedef struct {
    logic [1:0]  mode;
    int          bad_addr;
    logic [15:0] bad_val;
    logic        exp_err;
    logic [15:0] exp_cnt;
    logic [3:0]  exp_faddr;
    logic [15:0] exp_fexp;
    logic [15:0] exp_fact;
    logic [7:0]  exp_pc;
    int          exp_reads;
  } vec_t;

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // ---------------- instance A: BL=1, one pass, stop on error --------------
  logic        rstn_a, start_a, wdone_a, rvalid_a, busy_a, done_a, err_a;
  logic [1:0]  mode_a, cmd_a;
  logic [3:0]  addr_a, fea_a;
  logic [15:0] wdata_a, rdata_a, ecnt_a, fee_a, fet_a;
  logic [7:0]  pcnt_a;
  logic [84:0] outs_a;

  sdram_pattern_checker #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BURST_LENGTH(1),
                          .NUM_PASSES(1), .STOP_ON_ERROR(1'b1)) dut_a (
    .clk(clk), .reset_n(rstn_a), .start(start_a), .mode(mode_a), .command(cmd_a),
    .data_address(addr_a), .data_write(wdata_a), .data_write_done(wdone_a),
    .data_read(rdata_a), .data_read_valid(rvalid_a), .busy(busy_a), .done(done_a),
    .error(err_a), .error_count(ecnt_a), .pass_count(pcnt_a), .first_err_addr(fea_a),
    .first_err_expected(fee_a), .first_err_actual(fet_a));

  assign outs_a = {cmd_a, addr_a, wdata_a, busy_a, done_a, err_a, ecnt_a, pcnt_a,
                   fea_a, fee_a, fet_a};

  logic [15:0] mem_a [0:15];
  logic        stall_a = 1'b0;
  int          bad_addr = -1;
  logic [15:0] bad_val = 16'h0;
  logic [19:0] obs_a [0:1023];
  int          wr_total_a = 0;
  int          rd_total_a = 0;
  wr_t         q_a [$];

  always @(posedge clk) stall_a <= ($urandom_range(0, 3) == 0);
  assign wdone_a  = (cmd_a == 2'd1) && !stall_a;
  assign rvalid_a = (cmd_a == 2'd2) && !stall_a;
  assign rdata_a  = (int'(addr_a) == bad_addr) ? bad_val : mem_a[addr_a];

  always @(posedge clk) if (wdone_a) mem_a[addr_a] <= wdata_a;

  always @(negedge clk) begin
    if (wdone_a) begin
      obs_a[wr_total_a % 1024] <= {addr_a, wdata_a};
      wr_total_a <= wr_total_a + 1;
    end
    if (rvalid_a) rd_total_a <= rd_total_a + 1;
  end

  // ---------------- instance B: BL=4, two passes, strobes always high ------
  logic        rstn_bc, start_b, wdone_b, rvalid_b, busy_b, done_b, err_b;
  logic [1:0]  mode_b, cmd_b;
  logic [3:0]  addr_b, fea_b;
  logic [15:0] wdata_b, rdata_b, ecnt_b, fee_b, fet_b;
  logic [7:0]  pcnt_b;

  sdram_pattern_checker #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BURST_LENGTH(4),
                          .NUM_PASSES(2), .STOP_ON_ERROR(1'b1)) dut_b (
    .clk(clk), .reset_n(rstn_bc), .start(start_b), .mode(mode_b), .command(cmd_b),
    .data_address(addr_b), .data_write(wdata_b), .data_write_done(wdone_b),
    .data_read(rdata_b), .data_read_valid(rvalid_b), .busy(busy_b), .done(done_b),
    .error(err_b), .error_count(ecnt_b), .pass_count(pcnt_b), .first_err_addr(fea_b),
    .first_err_expected(fee_b), .first_err_actual(fet_b));

  logic [15:0] mem_b [0:15];
  logic [19:0] obs_b [0:255];
  logic [1:0]  cmds_b [0:511];
  int          wr_total_b = 0;
  int          cmd_n_b = 0;
  wr_t         q_b [$];

  assign wdone_b  = 1'b1;
  assign rvalid_b = 1'b1;
  assign rdata_b  = mem_b[addr_b];
  always @(posedge clk) if (cmd_b == 2'd1) mem_b[addr_b] <= wdata_b;

  always @(negedge clk) begin
    if (cmd_b == 2'd1) begin
      obs_b[wr_total_b % 256] <= {addr_b, wdata_b};
      wr_total_b <= wr_total_b + 1;
    end
    if (busy_b) begin
      cmds_b[cmd_n_b % 512] <= cmd_b;
      cmd_n_b <= cmd_n_b + 1;
    end
  end

  // ---------------- instance C: BL=8, endless, read bit 0 inverted ---------
  logic        start_c, wdone_c, rvalid_c, busy_c, done_c, err_c;
  logic [1:0]  mode_c, cmd_c;
  logic [3:0]  addr_c, fea_c;
  logic [15:0] wdata_c, rdata_c, ecnt_c, fee_c, fet_c;
  logic [7:0]  pcnt_c;

  sdram_pattern_checker #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BURST_LENGTH(8),
                          .NUM_PASSES(0), .STOP_ON_ERROR(1'b0)) dut_c (
    .clk(clk), .reset_n(rstn_bc), .start(start_c), .mode(mode_c), .command(cmd_c),
    .data_address(addr_c), .data_write(wdata_c), .data_write_done(wdone_c),
    .data_read(rdata_c), .data_read_valid(rvalid_c), .busy(busy_c), .done(done_c),
    .error(err_c), .error_count(ecnt_c), .pass_count(pcnt_c), .first_err_addr(fea_c),
    .first_err_expected(fee_c), .first_err_actual(fet_c));

  logic [15:0] mem_c [0:15];
  assign wdone_c  = 1'b1;
  assign rvalid_c = 1'b1;
  assign rdata_c  = mem_c[addr_c] ^ 16'h0001;
  always @(posedge clk) if (cmd_c == 2'd1) mem_c[addr_c] <= wdata_c;

  // ---------------- reference pattern ------------------------------------
  function automatic logic [15:0] pat(input logic [1:0] m, input int a, input int p);
    logic [15:0] v;
    logic [15:0] l;
    l = 16'hACE1;
    for (int i = 0; i < a; i++) l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    case (m)
      2'd0:    v = 16'(a);
      2'd1:    v = 16'(a) ^ 16'(a >> 16);
      2'd2:    v = l;
      default: v = ~16'(a);
    endcase
    return (p % 2 == 1) ? ~v : v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run_vec(input vec_t v);
    int  base_w, base_r, n;
    wr_t e;
    bad_addr = v.bad_addr;
    bad_val  = v.bad_val;
    base_w   = wr_total_a;
    base_r   = rd_total_a;
    @(negedge clk);
    start_a = 1'b1;
    mode_a  = v.mode;
    for (int a = 0; a < 16; a++) q_a.push_back({4'(a), pat(v.mode, a, 0)});
    @(negedge clk);
    start_a = 1'b0;
    mode_a  = v.mode ^ 2'b11;
    n = 0;
    while (!done_a && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("a_done", done_a, 1'b1);
    repeat (2) @(negedge clk);
    for (int k = base_w; k < wr_total_a; k++) begin
      if (q_a.size() == 0) begin
        check("a_extra_write", 1'b1, 1'b0);
      end else begin
        e = q_a.pop_front();
        check("a_wr_addr", obs_a[k % 1024][19:16], e.addr);
        check("a_wr_data", obs_a[k % 1024][15:0], e.data);
      end
    end
    check("a_missing_writes", q_a.size(), 0);
    q_a.delete();
    check("a_busy", busy_a, 1'b0);
    check("a_error", err_a, v.exp_err);
    check("a_err_count", ecnt_a, v.exp_cnt);
    check("a_first_addr", fea_a, v.exp_faddr);
    check("a_first_exp", fee_a, v.exp_fexp);
    check("a_first_act", fet_a, v.exp_fact);
    check("a_pass_count", pcnt_a, v.exp_pc);
    check("a_reads", rd_total_a - base_r, v.exp_reads);
  endtask

  vec_t tv [9];

  initial begin
    int  n, base_w, cur, len, wr_runs, rd_runs, bad_len, bad_gap, v;
    wr_t e;
    tv[0] = '{2'd0, -1, 16'h0000, 1'b0, 16'd0, 4'd0,  16'h0000, 16'h0000, 8'd1, 16};
    tv[1] = '{2'd1, -1, 16'h0000, 1'b0, 16'd0, 4'd0,  16'h0000, 16'h0000, 8'd1, 16};
    tv[2] = '{2'd3, -1, 16'h0000, 1'b0, 16'd0, 4'd0,  16'h0000, 16'h0000, 8'd1, 16};
    tv[3] = '{2'd3,  5, 16'h0000, 1'b1, 16'd1, 4'd5,  16'hFFFA, 16'h0000, 8'd0, 6};
    tv[4] = '{2'd0, 15, 16'h1234, 1'b1, 16'd1, 4'd15, 16'h000F, 16'h1234, 8'd0, 16};
    tv[5] = '{2'd2,  0, 16'h0000, 1'b1, 16'd1, 4'd0,  16'hACE1, 16'h0000, 8'd0, 1};
    tv[6] = '{2'd2,  1, 16'hFFFF, 1'b1, 16'd1, 4'd1,  16'hE270, 16'hFFFF, 8'd0, 2};
    tv[7] = '{2'd1, -1, 16'h0000, 1'b0, 16'd0, 4'd0,  16'h0000, 16'h0000, 8'd1, 16};
    tv[8] = '{2'd2, -1, 16'h0000, 1'b0, 16'd0, 4'd0,  16'h0000, 16'h0000, 8'd1, 16};

    rstn_a = 1'b0; rstn_bc = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    mode_a = 2'd0; mode_b = 2'd0; mode_c = 2'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs_a", outs_a, '0);
    rstn_a = 1'b1; rstn_bc = 1'b1;
    @(negedge clk);
    check("idle_outputs_a", outs_a, '0);

    for (int i = 0; i < 9; i++) run_vec(tv[i]);
    check("lfsr_word0", mem_a[0], 16'hACE1);
    check("lfsr_word1", mem_a[1], 16'hE270);

    // asynchronous reset in the middle of the write phase
    bad_addr = -1;
    base_w = wr_total_a;
    @(negedge clk);
    start_a = 1'b1; mode_a = 2'd0;
    @(negedge clk);
    start_a = 1'b0;
    n = 0;
    while (!(wr_total_a >= base_w + 3 && cmd_a == 2'd1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_write_reached", cmd_a, 2'd1);
    check("rst_pre_addr_nonzero", addr_a != 4'd0, 1'b1);
    #1 rstn_a = 1'b0;
    #1;
    check("rst_command", cmd_a, 2'd0);
    check("rst_outputs", outs_a, '0);
    @(negedge clk);
    rstn_a = 1'b1;
    run_vec(tv[0]);

    // two passes, BL=4, mode 1
    base_w = wr_total_b;
    @(negedge clk);
    start_b = 1'b1; mode_b = 2'd1;
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < 16; a++) q_b.push_back({4'(a), pat(2'd1, a, p)});
    @(negedge clk);
    start_b = 1'b0;
    n = 0;
    while (!done_b && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("b_done", done_b, 1'b1);
    repeat (2) @(negedge clk);
    for (int k = base_w; k < wr_total_b; k++) begin
      if (q_b.size() == 0) begin
        check("b_extra_write", 1'b1, 1'b0);
      end else begin
        e = q_b.pop_front();
        check("b_wr_addr", obs_b[k % 256][19:16], e.addr);
        check("b_wr_data", obs_b[k % 256][15:0], e.data);
      end
    end
    check("b_missing_writes", q_b.size(), 0);
    check("b_pass_count", pcnt_b, 8'd2);
    check("b_error", err_b, 1'b0);
    check("b_busy", busy_b, 1'b0);
    cur = -1; len = 0; wr_runs = 0; rd_runs = 0; bad_len = 0; bad_gap = 0;
    for (int k = 0; k <= cmd_n_b; k++) begin
      v = (k < cmd_n_b) ? int'(cmds_b[k % 512]) : -1;
      if (v == cur) begin
        len++;
      end else begin
        if (cur == 1) begin
          wr_runs++;
          if (len != 4) bad_len++;
        end else if (cur == 2) begin
          rd_runs++;
          if (len != 4) bad_len++;
        end else if (cur == 0 && len != 1) begin
          bad_gap++;
        end
        cur = v;
        len = 1;
      end
    end
    check("b_write_bursts", wr_runs, 8);
    check("b_read_bursts", rd_runs, 8);
    check("b_burst_lengths", bad_len, 0);
    check("b_gap_lengths", bad_gap, 0);

    // endless run with a faulty bit: counter must saturate, starts ignored
    @(negedge clk);
    start_c = 1'b1; mode_c = 2'd0;
    @(negedge clk);
    start_c = 1'b0;
    n = 0;
    while (ecnt_c != 16'hFFFF && n < 170000) begin
      @(negedge clk);
      n++;
    end
    check("c_sat_reached", ecnt_c, 16'hFFFF);
    for (int s = 0; s < 3; s++) begin
      repeat (37) @(negedge clk);
      start_c = 1'b1;
      @(negedge clk);
      start_c = 1'b0;
    end
    repeat (100) @(negedge clk);
    check("c_sat_hold", ecnt_c, 16'hFFFF);
    check("c_error", err_c, 1'b1);
    check("c_busy", busy_c, 1'b1);
    check("c_done", done_c, 1'b0);
    check("c_first_addr", fea_c, 4'd0);
    check("c_first_exp", fee_c, 16'h0000);
    check("c_first_act", fet_c, 16'h0001);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
